prog_loader_ctrl: RTL

- Boot/reload sequencer for the instruction memory of the MIPS core.
- Accepts a framed word stream over a valid/ready handshake: header, N program words, XOR checksum trailer.
- Writes program words to instruction memory at word addresses 0..N-1 while holding the core in reset.
- Releases the core only after the checksum matches. A mismatch or a malformed header parks the block in an error state with the core held.

---
 rtl/prog_loader_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/prog_loader_ctrl.sv
// Instruction-memory boot/reload sequencer: header, N program words, XOR trailer.
// Latency: a memory write appears one cycle after its stream transfer.
// Backpressure: in_ready is a decode of state; high in HDR/LOAD/CHK, low in RUN/ERR.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   in_valid/in_data  framed stream word, in_ready accepts it
//   reload            request a new load (acted on only while running)
//   im_we/im_addr/im_d  registered instruction memory write port
//   core_rst          holds the core in reset until a verified program is in place
//   load_busy/load_done/load_err  status: loading, one-cycle entry-to-run pulse, error
module prog_loader_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_d,
  output logic              core_rst,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_LOAD = 3'd1,
    S_CHK  = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] csum;
  logic [ADDR_W-1:0] last_addr;
  logic              xfer;

  assign in_ready  = (state == S_HDR) || (state == S_LOAD) || (state == S_CHK);
  assign xfer      = in_valid && in_ready;
  // cnt is non-zero whenever LOAD is active, so this never underflows in use.
  assign last_addr = ADDR_W'(cnt) - ADDR_W'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR: begin
        if (xfer) begin
          if (in_data[31:16] != 16'd0)
            state_nxt = S_ERR;
          else if (in_data[15:0] != 16'd0)
            state_nxt = S_LOAD;
          else
            state_nxt = S_CHK;
        end
      end
      S_LOAD: begin
        if (xfer && (addr == last_addr))
          state_nxt = S_CHK;
      end
      S_CHK: begin
        if (xfer)
          state_nxt = (in_data == csum) ? S_RUN : S_ERR;
      end
      S_RUN: begin
        if (reload)
          state_nxt = S_HDR;
      end
      S_ERR: state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  // State and all status outputs are registered together, so core_rst and
  // load_done change in the very cycle the new state becomes visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_HDR;
      cnt       <= '0;
      addr      <= '0;
      csum      <= '0;
      im_we     <= 1'b0;
      im_addr   <= '0;
      im_d      <= '0;
      core_rst  <= 1'b1;
      load_busy <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      im_we     <= 1'b0;
      core_rst  <= (state_nxt != S_RUN);
      load_busy <= (state_nxt == S_HDR) || (state_nxt == S_LOAD) || (state_nxt == S_CHK);
      load_done <= (state_nxt == S_RUN) && (state != S_RUN);
      load_err  <= (state_nxt == S_ERR);

      if (xfer && (state == S_HDR) && (in_data[31:16] == 16'd0)) begin
        cnt  <= in_data[15:0];
        addr <= '0;
        csum <= '0;
      end

      // The trailer (CHK) is compared only; it is never written to memory.
      if (xfer && (state == S_LOAD)) begin
        im_we   <= 1'b1;
        im_addr <= addr;
        im_d    <= in_data;
        csum    <= csum ^ in_data;
        addr    <= addr + ADDR_W'(1);
      end
    end
  end

endmodule
